// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: state encodings and abort read data shared by the bus arbiter
package bus_arbiter_pkg;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_GNT0 = 2'd1;
  localparam logic [1:0] ARB_GNT1 = 2'd2;
  localparam logic [1:0] ARB_ABORT = 2'd3;
  localparam logic [31:0] ARB_ABORT_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/bus_arb_timeout.sv
// bus_arb_timeout: granted-transaction watchdog, built only with BUS_ARB_TIMEOUT_EN
`ifdef BUS_ARB_TIMEOUT_EN
module bus_arb_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic hit,
  output logic expire
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;
  // count stalled grant cycles; zero outside a grant so each grant starts fresh
  always_ff @(posedge clk) begin
    cnt <= (rst | ~active | hit) ? '0 : cnt + CW'(1);
  end
  assign expire = active & ~hit & (cnt == CW'(TIMEOUT - 1));
endmodule
`endif

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-master bus arbiter; BUS_ARB_TIMEOUT_EN adds hung-slave abort
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef BUS_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_a,
  input  logic [DW-1:0] m0_d,
  input  logic          m0_we,
  input  logic          m0_rd,
  output logic [DW-1:0] m0_spo,
  output logic          m0_ready,
  input  logic [AW-1:0] m1_a,
  input  logic [DW-1:0] m1_d,
  input  logic          m1_we,
  input  logic          m1_rd,
  output logic [DW-1:0] m1_spo,
  output logic          m1_ready,
  output logic [AW-1:0] s_a,
  output logic [DW-1:0] s_d,
  output logic          s_we,
  output logic          s_rd,
  input  logic [DW-1:0] s_spo,
  input  logic          s_ready,
  output logic [1:0]    grant
`ifdef BUS_ARB_TIMEOUT_EN
  , output logic        err_irq
  , output logic        err_owner
`endif
);
  logic [1:0] state, state_nxt;
  logic last_grant, last_grant_nxt;
  logic req0, req1, own_req, g0, g1, ab, expire;
  assign req0 = m0_we | m0_rd;
  assign req1 = m1_we | m1_rd;
  assign g0 = state == ARB_GNT0;
  assign g1 = state == ARB_GNT1;
  assign own_req = g1 ? req1 : req0;
  assign grant = {g1, g0};
`ifdef BUS_ARB_TIMEOUT_EN
  assign ab = state == ARB_ABORT;
  assign err_irq = ab;
  bus_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst(rst),
    .active(g0 | g1),
    .hit(s_ready),
    .expire(expire)
  );
  // remember which master was cut off by the last timeout
  always_ff @(posedge clk) begin
    if (rst) err_owner <= 1'b0;
    else if (state_nxt == ARB_ABORT) err_owner <= last_grant_nxt;
  end
`else
  assign ab = 1'b0;
  assign expire = 1'b0;
`endif
  // arbitrate in IDLE, release on completion, request drop or timeout
  always_comb begin
    state_nxt = state;
    last_grant_nxt = last_grant;
    if (state == ARB_IDLE)
      state_nxt = (req0 & (last_grant | ~req1)) ? ARB_GNT0 : req1 ? ARB_GNT1 : ARB_IDLE;
    else if (ab)
      state_nxt = ARB_IDLE;
    else if (s_ready) begin
      state_nxt = ARB_IDLE;
      last_grant_nxt = g1;
    end else if (!own_req)
      state_nxt = ARB_IDLE;
    else if (expire) begin
      state_nxt = ARB_ABORT;
      last_grant_nxt = g1;
    end
  end
  // last_grant starts at 1 so master 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end
  assign s_a = g0 ? m0_a : g1 ? m1_a : '0;
  assign s_d = g0 ? m0_d : g1 ? m1_d : '0;
  assign s_we = g0 ? m0_we : g1 & m1_we;
  assign s_rd = g0 ? m0_rd : g1 & m1_rd;
  assign m0_ready = (g0 & s_ready & req0) | (ab & ~last_grant);
  assign m1_ready = (g1 & s_ready & req1) | (ab & last_grant);
  assign m0_spo = g0 ? s_spo : (ab & ~last_grant) ? DW'(ARB_ABORT_DATA) : '0;
  assign m1_spo = g1 ? s_spo : (ab & last_grant) ? DW'(ARB_ABORT_DATA) : '0;
endmodule
